// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: machine word and the data-request FSM state.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } req_state_t;

endpackage

// File: rtl/llsc_link.sv
// llsc_link: LL/SC link register (valid bit + linked address) with address compare.
module llsc_link #(
  parameter int ADDR_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              set,
  input  logic              clear,
  input  logic [ADDR_W-1:0] addr,
  input  logic [ADDR_W-1:0] check_addr,
  output logic              valid,
  output logic              match
);

  logic              r_valid;
  logic [ADDR_W-1:0] r_addr;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_valid <= 1'b0;
      r_addr  <= '0;
    end else if (set) begin
      r_valid <= 1'b1;
      r_addr  <= addr;
    end else if (clear) begin
      r_valid <= 1'b0;
    end
  end

  assign valid = r_valid;
  assign match = r_valid && (r_addr == check_addr);

endmodule

// File: rtl/dmem_request_ctrl.sv
// dmem_request_ctrl: data-memory request FSM with registered enables and LL/SC link.
// Optional request watchdog is compiled in with `define REQ_TIMEOUT_EN.
module dmem_request_ctrl
  import cpu_types_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int WORD_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ihit,
  input  logic              dhit,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic              datomic,
  input  logic              halt,
  input  logic              flush,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [ADDR_W-1:0] dmemaddr,
  output logic [WORD_W-1:0] dmemstore,
  output logic              pcWEN,
  output logic              stall,
  output logic              sc_fail,
  output logic              timeout_err
);

  req_state_t        r_state, w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [WORD_W-1:0] r_store;
  logic              r_atomic;
  logic              w_busy, w_go, w_sc_bad, w_launch_rd, w_launch_wr, w_timeout;
  logic              w_link_valid, w_link_match, w_link_set, w_link_clear, w_pc;
  logic [ADDR_W-1:0] w_check_addr;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  assign w_busy      = (r_state != IDLE);
  assign w_go        = (r_state == IDLE) && ihit && !halt && !flush;
  // A failing SC completes locally: no memory write, the PC simply advances.
  assign w_sc_bad    = w_go && dWEN && datomic && !w_link_match;
  assign w_launch_wr = w_go && dWEN && !w_sc_bad;
  assign w_launch_rd = w_go && !dWEN && dREN;

  // In IDLE the link is checked against the incoming SC; while busy, against the store in flight.
  assign w_check_addr = w_busy ? r_addr : daddr;
  assign w_link_set   = (r_state == READ) && dhit && r_atomic;
  assign w_link_clear = (r_state == WRITE) && dhit && w_link_match;

  llsc_link #(.ADDR_W(ADDR_W)) u_link (
    .CLK        (CLK),
    .nRST       (nRST),
    .set        (w_link_set),
    .clear      (w_link_clear),
    .addr       (r_addr),
    .check_addr (w_check_addr),
    .valid      (w_link_valid),
    .match      (w_link_match)
  );

`ifdef REQ_TIMEOUT_EN
  localparam int WDOG_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WDOG_W-1:0] r_wdog;
  logic              r_timeout_err;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_wdog        <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (w_launch_rd || w_launch_wr) r_wdog <= '0;
      else if (w_busy)                r_wdog <= r_wdog + 1'b1;
      if (w_timeout) r_timeout_err <= 1'b1;
    end
  end

  assign w_timeout   = w_busy && !dhit && (r_wdog == WDOG_W'(TIMEOUT_CYCLES - 1));
  assign timeout_err = r_timeout_err;
`else
  assign w_timeout   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state  <= IDLE;
      r_addr   <= '0;
      r_store  <= '0;
      r_atomic <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_launch_rd || w_launch_wr) begin
        r_addr   <= daddr;
        r_store  <= dstore;
        r_atomic <= datomic;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    w_pc   = 1'b0;
    case (r_state)
      IDLE: begin
        w_pc = (ihit && !dREN && !dWEN) || w_sc_bad;
        if (w_launch_wr)      w_next = WRITE;
        else if (w_launch_rd) w_next = READ;
      end
      READ, WRITE: begin
        w_pc = dhit || w_timeout;
        if (dhit || w_timeout) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign pcWEN     = w_pc && !halt;
  assign stall     = w_busy;
  assign sc_fail   = w_sc_bad;
  assign dmemREN   = (r_state == READ);
  assign dmemWEN   = (r_state == WRITE);
  assign dmemaddr  = r_addr;
  assign dmemstore = r_store;

endmodule

// File: tb/tb_dmem_request_ctrl.sv
// Bench for dmem_request_ctrl: directed scenarios plus random traffic against a request-level model.
module tb_dmem_request_ctrl;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        ihit, dhit, dREN, dWEN, datomic, halt, flush;
  logic [31:0] daddr, dstore;
  logic        dmemREN, dmemWEN, pcWEN, stall, sc_fail, timeout_err;
  logic [31:0] dmemaddr, dmemstore;

  int n_vec = 0;
  int n_err = 0;

  // Model: one outstanding request (or none) and the LL link.
  bit          m_busy, m_wr, m_atomic, m_lv;
  logic [31:0] m_addr, m_store, m_la;
  logic        s_scfail, s_pcwen;
  logic [31:0] addr_tab [4] = '{32'h100, 32'h200, 32'h300, 32'h104};

  dmem_request_ctrl dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .dREN(dREN), .dWEN(dWEN),
    .datomic(datomic), .halt(halt), .flush(flush), .daddr(daddr), .dstore(dstore),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .pcWEN(pcWEN), .stall(stall), .sc_fail(sc_fail), .timeout_err(timeout_err)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_wr = 0; m_atomic = 0; m_lv = 0;
    m_addr = '0; m_store = '0; m_la = '0;
  endtask

  task automatic set_in(input logic ih, input logic dh, input logic rn, input logic wn,
                        input logic at, input logic hl, input logic fl,
                        input logic [31:0] a, input logic [31:0] s);
    ihit = ih; dhit = dh; dREN = rn; dWEN = wn; datomic = at; halt = hl; flush = fl;
    daddr = a; dstore = s;
  endtask

  // Called 1 time unit after a rising edge with inputs already driven.
  task automatic step();
    bit go, link_hit, e_sc, e_pc;
    #3;
    check("stall",     32'(stall),   32'(m_busy));
    check("dmemREN",   32'(dmemREN), 32'(m_busy && !m_wr));
    check("dmemWEN",   32'(dmemWEN), 32'(m_busy && m_wr));
    check("dmemaddr",  dmemaddr,     m_addr);
    check("dmemstore", dmemstore,    m_store);
    check("timeout",   32'(timeout_err), 32'(0));
    link_hit = m_lv && (m_la == daddr);
    go   = !m_busy && ihit && !halt && !flush;
    e_sc = go && dWEN && datomic && !link_hit;
    if (m_busy) e_pc = dhit && !halt;
    else        e_pc = !halt && ((ihit && !dREN && !dWEN) || e_sc);
    check("pcWEN",   32'(pcWEN),   32'(e_pc));
    check("sc_fail", 32'(sc_fail), 32'(e_sc));
    s_scfail = sc_fail;
    s_pcwen  = pcWEN;
    @(posedge CLK);
    if (m_busy) begin
      if (dhit) begin
        if (!m_wr && m_atomic) begin m_lv = 1; m_la = m_addr; end
        if (m_wr && m_lv && (m_la == m_addr)) m_lv = 0;
        m_busy = 0;
      end
    end else if (go && !e_sc && (dWEN || dREN)) begin
      m_busy = 1; m_wr = dWEN; m_atomic = datomic; m_addr = daddr; m_store = dstore;
    end
    #1;
  endtask

  // Launch one request, wait `waits` cycles, then complete it with dhit.
  task automatic request(input logic wr, input logic at, input logic [31:0] a,
                         input logic [31:0] s, input int waits);
    set_in(1, 0, !wr, wr, at, 0, 0, a, s);
    step();
    for (int k = 0; k < waits; k++) begin
      set_in(0, 0, !wr, wr, at, 0, 0, a, s);
      step();
    end
    set_in(0, 1, !wr, wr, at, 0, 0, a, s);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1);
  end

  initial begin
    nRST = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    check("rst_ren",   32'(dmemREN),   32'(0));
    check("rst_wen",   32'(dmemWEN),   32'(0));
    check("rst_addr",  dmemaddr,       32'h0);
    check("rst_store", dmemstore,      32'h0);
    check("rst_stall", 32'(stall),     32'(0));
    check("rst_tmo",   32'(timeout_err), 32'(0));
    nRST = 1'b1;

    // Plain load, 3 wait cycles, then dhit.
    set_in(1, 0, 1, 0, 0, 0, 0, 32'h100, 32'h0);
    step();
    check("ld_ren",  32'(dmemREN), 32'(1));
    check("ld_addr", dmemaddr,     32'h100);
    for (int k = 0; k < 3; k++) begin set_in(0, 0, 1, 0, 0, 0, 0, 32'h100, 0); step(); end
    set_in(0, 1, 1, 0, 0, 0, 0, 32'h100, 0);
    step();
    check("ld_pc",   32'(s_pcwen), 32'(1));
    check("ld_done", 32'(dmemREN), 32'(0));

    // Store wins over a simultaneous load.
    set_in(1, 0, 1, 1, 0, 0, 0, 32'h104, 32'hDEADBEEF);
    step();
    check("st_wen",   32'(dmemWEN), 32'(1));
    check("st_ren",   32'(dmemREN), 32'(0));
    check("st_store", dmemstore,    32'hDEADBEEF);
    set_in(0, 1, 1, 1, 0, 0, 0, 32'h104, 32'hDEADBEEF);
    step();

    // LL then SC succeeds; repeated SC fails and does not write.
    request(0, 1, 32'h200, 0, 1);
    set_in(1, 0, 0, 1, 1, 0, 0, 32'h200, 32'h11);
    step();
    check("sc1_fail", 32'(s_scfail), 32'(0));
    check("sc1_wen",  32'(dmemWEN),  32'(1));
    set_in(0, 1, 0, 1, 1, 0, 0, 32'h200, 32'h11);
    step();
    set_in(1, 0, 0, 1, 1, 0, 0, 32'h200, 32'h22);
    step();
    check("sc2_fail", 32'(s_scfail), 32'(1));
    check("sc2_pc",   32'(s_pcwen),  32'(1));
    check("sc2_wen",  32'(dmemWEN),  32'(0));
    set_in(0, 0, 0, 0, 0, 0, 0, 32'h0, 0);
    step();

    // Plain store to the linked address breaks the link.
    request(0, 1, 32'h300, 0, 0);
    request(1, 0, 32'h300, 32'h33, 0);
    set_in(1, 0, 0, 1, 1, 0, 0, 32'h300, 32'h44);
    step();
    check("brk_fail", 32'(s_scfail), 32'(1));

    // Halt blocks launch and PC; flush mid-read does not abort.
    set_in(1, 0, 1, 0, 0, 1, 0, 32'h100, 0);
    step();
    check("halt_pc",    32'(s_pcwen), 32'(0));
    check("halt_stall", 32'(stall),   32'(0));
    set_in(1, 0, 1, 0, 0, 0, 0, 32'h100, 0);
    step();
    for (int k = 0; k < 3; k++) begin set_in(0, 0, 1, 0, 0, 0, 1, 32'h100, 0); step(); end
    check("flush_ren", 32'(dmemREN), 32'(1));
    set_in(0, 1, 1, 0, 0, 0, 1, 32'h100, 0);
    step();

    // Asynchronous reset mid-request drops enables and the link at once.
    request(0, 1, 32'h200, 0, 0);
    set_in(1, 0, 1, 0, 0, 0, 0, 32'h100, 0);
    step();
    #2 nRST = 1'b0;
    #1;
    check("arst_ren",   32'(dmemREN), 32'(0));
    check("arst_stall", 32'(stall),   32'(0));
    model_reset();
    set_in(0, 0, 0, 0, 0, 0, 0, 32'h0, 0);
    @(posedge CLK);
    #1 nRST = 1'b1;
    set_in(1, 0, 0, 1, 1, 0, 0, 32'h200, 32'h55);
    step();
    check("arst_sc", 32'(s_scfail), 32'(1));

    // Random traffic; request operands held steady while a request is outstanding.
    for (int i = 0; i < 1500; i++) begin
      ihit  = ($urandom_range(3) != 0);
      dhit  = ($urandom_range(2) == 0);
      halt  = ($urandom_range(7) == 0);
      flush = ($urandom_range(7) == 0);
      if (!m_busy) begin
        dREN    = 1'($urandom_range(1));
        dWEN    = ($urandom_range(2) == 0);
        datomic = 1'($urandom_range(1));
        daddr   = addr_tab[$urandom_range(3)];
        dstore  = $urandom;
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_request_ctrl.md
DMEM_REQUEST_CTRL -- requirements
Module: dmem_request_ctrl

Interface
REQ-001 Parameter ADDR_W, 32, data-memory address width in bits.
REQ-002 Parameter WORD_W, 32, data word width in bits.
REQ-003 Parameter TIMEOUT_CYCLES, 16, maximum cycles a data request may stay outstanding; only used when the watchdog is compiled in.
REQ-004 CLK  in  1  clock; all state SHALL update on its rising edge.
REQ-005 nRST  in  1  reset, asynchronous, active-low.
REQ-006 ihit, dhit  in  1 each  instruction-fetch hit; data-access hit.
REQ-007 dREN, dWEN, datomic  in  1 each  decoded load; decoded store; LL/SC qualifier.
REQ-008 halt, flush  in  1 each  processor halted; pipeline flush.
REQ-009 daddr  in  ADDR_W  data address; dstore  in  WORD_W  store data.
REQ-010 dmemREN, dmemWEN  out  1 each  registered data read/write enables.
REQ-011 dmemaddr  out  ADDR_W; dmemstore  out  WORD_W  latched request address and store data.
REQ-012 pcWEN, stall, sc_fail, timeout_err  out  1 each  PC advance; pipeline hold; SC failed; watchdog fired.

Function
REQ-013 FSM states SHALL be IDLE, READ, WRITE; stall SHALL be 1 in any state other than IDLE.
REQ-014 In IDLE with ihit=1, halt=0, flush=0: dWEN=1 SHALL move the FSM to WRITE (store has priority over load); otherwise dREN=1 SHALL move it to READ; dmemaddr and dmemstore SHALL latch daddr and dstore on the same edge.
REQ-015 dmemREN SHALL equal (state==READ); dmemWEN SHALL equal (state==WRITE); both SHALL be registered, asserting one cycle after the launching ihit.
REQ-016 In READ or WRITE, dhit=1 SHALL return the FSM to IDLE at the next edge and deassert the enables.
REQ-017 pcWEN SHALL be combinational: 1 for ihit in IDLE with no data op and halt=0, or for dhit in READ/WRITE; 0 otherwise.
REQ-018 The link register SHALL hold a valid bit and an ADDR_W address.
REQ-019 A completing load with datomic=1 SHALL set the link valid bit and record dmemaddr.
REQ-020 A store launch with datomic=1 and link invalid or address mismatch SHALL NOT enter WRITE; it SHALL pulse sc_fail and pcWEN for that cycle only.
REQ-021 A successful SC, or any completed store to the linked address, SHALL clear the link valid bit on dhit.
REQ-022 flush SHALL block new launches; flush mid-request SHALL NOT abort the request, which completes on dhit.
REQ-023 halt SHALL block new launches and force pcWEN=0; an in-flight request SHALL still complete.
REQ-024 dhit while in IDLE SHALL be ignored.

Reset
REQ-025 On nRST=0: state=IDLE, dmemREN=0, dmemWEN=0, dmemaddr=0, dmemstore=0, link invalid, sc_fail=0, timeout_err=0, watchdog counter=0.
REQ-026 Reset asserted mid-request SHALL drop the enables immediately (asynchronously) with no completion.

Configuration
REQ-027 With REQ_TIMEOUT_EN defined, a counter SHALL increment every cycle in READ/WRITE and clear on each new launch.
REQ-028 With REQ_TIMEOUT_EN defined, if the counter reaches TIMEOUT_CYCLES without dhit, the FSM SHALL return to IDLE with enables cleared, pulse pcWEN, and set timeout_err sticky until reset.
REQ-029 Without REQ_TIMEOUT_EN, no counter SHALL exist, timeout_err SHALL be tied 0, and requests SHALL wait on dhit indefinitely.

Structure
REQ-030 The req_state_t enum (IDLE, READ, WRITE) SHALL be defined in cpu_types_pkg, alongside the existing word_t type.
REQ-031 The link tracking SHALL be a sub-module named llsc_link with inputs set, clear, addr, and check_addr, and outputs valid and match.

Verification
REQ-032 Load: ihit=1, dREN=1, daddr=0x100 -> next cycle dmemREN=1, dmemaddr=0x100, stall=1; dhit after 3 cycles -> pcWEN=1, then dmemREN=0.
REQ-033 Store priority: ihit, dREN=1, dWEN=1, dstore=0xDEADBEEF -> dmemWEN=1, dmemREN=0, dmemstore=0xDEADBEEF.
REQ-034 LL/SC: LL at 0x200 completes; SC at 0x200 -> WRITE, sc_fail=0; second SC at 0x200 -> sc_fail=1 for one cycle, dmemWEN stays 0.
REQ-035 Link break: LL at 0x300, plain store at 0x300, SC at 0x300 -> sc_fail=1.
REQ-036 Halt/flush: halt=1 with ihit and dREN -> no launch, pcWEN=0; flush asserted mid-READ -> dmemREN held until dhit.
REQ-037 With REQ_TIMEOUT_EN and TIMEOUT_CYCLES=4: READ with no dhit -> after 4 cycles dmemREN=0, timeout_err=1 held; nRST clears it.
